// File: rtl/rggen_register_bus_initiator_pkg.sv
// -----------------------------------------------------------------------------
// rggen_register_bus_initiator_pkg
//   Shared encodings for the internal register bus: access codes, response
//   status codes, the initiator FSM state type and a helper that sizes the
//   BUSY timeout counter.
// -----------------------------------------------------------------------------
package rggen_register_bus_initiator_pkg;

  // Access codes: bit0 = write, bit1 = non-posted
  localparam logic [1:0] RGGEN_READ         = 2'b10;
  localparam logic [1:0] RGGEN_WRITE        = 2'b11;
  localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;
  localparam int         RGGEN_WRITE_BIT    = 0;

  // Response status codes
  localparam logic [1:0] RGGEN_OKAY         = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPONSE
  } initiator_state_e;

  // A disabled timeout still gets a 1-bit counter so no zero-width vector exists
  function automatic int timeout_counter_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/rggen_register_bus_initiator_if.sv
// -----------------------------------------------------------------------------
// rggen_register_bus_initiator_if
//   Host-side channel of the register bus initiator: request valid/ready with
//   access/address/write-data/strobe, and response valid/ready with status and
//   read data. Signal names carry the direction as seen by the initiator.
//   master : the host / protocol adapter front end
//   slave  : the initiator
// -----------------------------------------------------------------------------
interface rggen_register_bus_initiator_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);

  logic                     i_host_valid;
  logic                     o_host_ready;
  logic [1:0]               i_host_access;
  logic [ADDRESS_WIDTH-1:0] i_host_address;
  logic [BUS_WIDTH-1:0]     i_host_write_data;
  logic [BUS_WIDTH/8-1:0]   i_host_strobe;
  logic                     o_response_valid;
  logic                     i_response_ready;
  logic [1:0]               o_response_status;
  logic [BUS_WIDTH-1:0]     o_response_read_data;

  modport master (
    output i_host_valid, i_host_access, i_host_address, i_host_write_data,
           i_host_strobe, i_response_ready,
    input  o_host_ready, o_response_valid, o_response_status, o_response_read_data
  );

  modport slave (
    input  i_host_valid, i_host_access, i_host_address, i_host_write_data,
           i_host_strobe, i_response_ready,
    output o_host_ready, o_response_valid, o_response_status, o_response_read_data
  );

endinterface

// File: rtl/rggen_or_reducer.sv
// -----------------------------------------------------------------------------
// rggen_or_reducer
//   Masks each WIDTH-bit slice of i_data with its select bit and ORs the
//   surviving slices together.
//   i_select : N select bits, slice k kept when i_select[k] = 1
//   i_data   : N slices, slice k at [WIDTH*k +: WIDTH]
//   o_data   : OR of the selected slices
// -----------------------------------------------------------------------------
module rggen_or_reducer #(
  parameter int WIDTH = 32,
  parameter int N     = 1
) (
  input  logic [N-1:0]       i_select,
  input  logic [WIDTH*N-1:0] i_data,
  output logic [WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++) begin
      o_data = o_data | (i_data[WIDTH*k +: WIDTH] & {WIDTH{i_select[k]}});
    end
  end

endmodule

// File: rtl/rggen_register_bus_initiator.sv
// -----------------------------------------------------------------------------
// rggen_register_bus_initiator
//   Requesting end of the internal register bus. Accepts one host request,
//   broadcasts it to all register blocks, merges their responses into a single
//   host response and holds it until the host takes it.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   host_bus (slave)   : host request and response channel
//   o_register_*       : request broadcast to the register blocks
//   i_register_active  : per-block address hit
//   i_register_ready   : per-block done
//   i_register_status  : per-block status, block k at [2k +: 2]
//   i_register_read_data : per-block read data, block k at [BUS_WIDTH*k +: BUS_WIDTH]
// -----------------------------------------------------------------------------
module rggen_register_bus_initiator
  import rggen_register_bus_initiator_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int REGISTERS      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  rggen_register_bus_initiator_if.slave  host_bus,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int             COUNT_W        = timeout_counter_width(TIMEOUT_CYCLES);
  localparam bit             TIMEOUT_ENABLE = (TIMEOUT_CYCLES > 0);
  localparam logic [COUNT_W-1:0] TIMEOUT_LIMIT = COUNT_W'(TIMEOUT_CYCLES);

  function automatic logic [BUS_WIDTH-1:0] expand_strobe(input logic [BUS_WIDTH/8-1:0] strobe);
    logic [BUS_WIDTH-1:0] mask;
    mask = '0;
    for (int b = 0; b < BUS_WIDTH / 8; b++) begin
      mask[8*b +: 8] = {8{strobe[b]}};
    end
    return mask;
  endfunction

  initiator_state_e         state_q, state_d;
  logic                     host_ready_q, host_ready_d;
  logic                     register_valid_q, register_valid_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [BUS_WIDTH-1:0]     strobe_q, strobe_d;
  logic                     response_valid_q, response_valid_d;
  logic [1:0]               status_q, status_d;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
  logic [COUNT_W-1:0]       count_q, count_d;

  logic                     any_active;
  logic                     done;
  logic                     timeout;
  logic [1:0]               merged_status;
  logic [BUS_WIDTH-1:0]     merged_read_data;
  logic                     respond;
  logic [1:0]               respond_status;
  logic [BUS_WIDTH-1:0]     respond_data;

  rggen_or_reducer #(
    .WIDTH (BUS_WIDTH),
    .N     (REGISTERS)
  ) u_read_data_reducer (
    .i_select (i_register_active),
    .i_data   (i_register_read_data),
    .o_data   (merged_read_data)
  );

  rggen_or_reducer #(
    .WIDTH (2),
    .N     (REGISTERS)
  ) u_status_reducer (
    .i_select (i_register_active),
    .i_data   (i_register_status),
    .o_data   (merged_status)
  );

  assign any_active = |i_register_active;
  assign done       = |(i_register_active & i_register_ready);
  assign timeout    = TIMEOUT_ENABLE && (count_q == TIMEOUT_LIMIT);

  always_comb begin
    state_d          = state_q;
    host_ready_d     = host_ready_q;
    register_valid_d = register_valid_q;
    access_d         = access_q;
    address_d        = address_q;
    write_data_d     = write_data_q;
    strobe_d         = strobe_q;
    response_valid_d = response_valid_q;
    status_d         = status_q;
    read_data_d      = read_data_q;
    count_d          = count_q;
    respond          = 1'b0;
    respond_status   = RGGEN_OKAY;
    respond_data     = '0;

    case (state_q)
      IDLE: begin
        if (host_bus.i_host_valid) begin
          state_d          = BUSY;
          host_ready_d     = 1'b0;
          register_valid_d = 1'b1;
          access_d         = host_bus.i_host_access;
          address_d        = host_bus.i_host_address;
          write_data_d     = host_bus.i_host_write_data;
          strobe_d         = expand_strobe(host_bus.i_host_strobe);
          count_d          = '0;
        end
      end
      BUSY: begin
        if (count_q != TIMEOUT_LIMIT) begin
          count_d = count_q + COUNT_W'(1);
        end
        // Decode error wins over done, done wins over timeout
        if (!any_active) begin
          respond        = 1'b1;
          respond_status = RGGEN_DECODE_ERROR;
        end else if (done) begin
          respond        = 1'b1;
          respond_status = merged_status;
          // Read data is only returned for successful reads
          if (!access_q[RGGEN_WRITE_BIT] && (merged_status == RGGEN_OKAY)) begin
            respond_data = merged_read_data;
          end
        end else if (timeout) begin
          respond        = 1'b1;
          respond_status = RGGEN_SLAVE_ERROR;
        end
        if (respond) begin
          state_d          = RESPONSE;
          register_valid_d = 1'b0;
          response_valid_d = 1'b1;
          status_d         = respond_status;
          read_data_d      = respond_data;
        end
      end
      RESPONSE: begin
        if (host_bus.i_response_ready) begin
          state_d          = IDLE;
          response_valid_d = 1'b0;
          host_ready_d     = 1'b1;
        end
      end
      default: begin
        state_d          = IDLE;
        host_ready_d     = 1'b1;
        register_valid_d = 1'b0;
        response_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= IDLE;
      host_ready_q     <= 1'b1;
      register_valid_q <= 1'b0;
      access_q         <= '0;
      address_q        <= '0;
      write_data_q     <= '0;
      strobe_q         <= '0;
      response_valid_q <= 1'b0;
      status_q         <= '0;
      read_data_q      <= '0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      host_ready_q     <= host_ready_d;
      register_valid_q <= register_valid_d;
      access_q         <= access_d;
      address_q        <= address_d;
      write_data_q     <= write_data_d;
      strobe_q         <= strobe_d;
      response_valid_q <= response_valid_d;
      status_q         <= status_d;
      read_data_q      <= read_data_d;
      count_q          <= count_d;
    end
  end

  assign host_bus.o_host_ready          = host_ready_q;
  assign host_bus.o_response_valid      = response_valid_q;
  assign host_bus.o_response_status     = status_q;
  assign host_bus.o_response_read_data  = read_data_q;
  assign o_register_valid               = register_valid_q;
  assign o_register_access              = access_q;
  assign o_register_address             = address_q;
  assign o_register_write_data          = write_data_q;
  assign o_register_strobe              = strobe_q;

endmodule
